uart_rx_fifo: RTL and testbench

// - Receive buffer directly downstream of the UART receiver. Captures each byte the receiver

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: data width (matches the receiver) and receive buffer depth.
package uart_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array for the receive queue: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int W     = UART_DATA_W,
  parameter  int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures and acknowledges each byte, queues it,
// and presents the queue as a first-word-fall-through valid/ready stream with sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int N     = UART_DATA_W,
  parameter  int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_ready,
  input  logic [N-1:0] rx_data,
  output logic         rx_ready_clr,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [AW:0]  count,
  output logic         full,
  output logic         overrun,
  input  logic         overrun_clr
);

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        rx_ready_clr_q, rx_ready_clr_d;
  logic        overrun_q, overrun_d;

  logic        cap_s, push_s, pop_s, drop_s;
  logic        empty_s, full_s;
  logic [AW:0] count_s;

  // Queue status and handshake decode from registered pointers
  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_s = wr_ptr_q - rd_ptr_q;
    // The ack mask stops the still-high level from being captured twice
    cap_s   = rx_ready & ~rx_ready_clr_q;
    pop_s   = ~empty_s & m_ready;
    push_s  = cap_s & (~full_s | pop_s);
    drop_s  = cap_s & full_s & ~pop_s;
  end

  // Next-state for pointers, acknowledge pulse and sticky overrun
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rx_ready_clr_d = cap_s;
    overrun_d      = overrun_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Setting wins over a same-cycle clear
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rx_ready_clr_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rx_ready_clr_q <= rx_ready_clr_d;
      overrun_q      <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (m_data)
  );

  assign rx_ready_clr = rx_ready_clr_q;
  assign m_valid      = ~empty_s;
  assign full         = full_s;
  assign count        = count_s;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: receiver handshake model, table of push/pop steps,
// and hand-written corner sequences, all checked against a scoreboard queue.
module tb_uart_rx_fifo;
  localparam int N = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx_ready;
  logic [N-1:0]  rx_data;
  logic          rx_ready_clr;
  logic [N-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          full;
  logic          overrun;
  logic          overrun_clr;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] sb[$];

  typedef struct {
    bit          is_pop;
    logic [7:0]  data;
    int          exp_count;
    bit          exp_valid;
    bit          exp_full;
  } vec_t;
  vec_t vecs[8];

  uart_rx_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .full         (full),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: hold the level until an edge samples rx_ready_clr=1, then drop it
  task automatic send_byte(input logic [7:0] b, input bit drop, output int pulses);
    bit done;
    bit seen;
    done = 1'b0;
    pulses = 0;
    rx_ready = 1'b1;
    rx_data = b;
    for (int i = 0; i < 8 && !done; i++) begin
      seen = rx_ready_clr;
      tick();
      if (rx_ready_clr) pulses++;
      if (seen) begin
        rx_ready = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("ack_timeout", 32'd0, 32'd1);
      rx_ready = 1'b0;
    end
    if (!drop) sb.push_back(b);
  endtask

  task automatic pop_one();
    logic [7:0] exp;
    chk("pop_valid", {31'd0, m_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk("pop_data", {24'd0, m_data}, {24'd0, exp});
      if (m_valid) begin
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int p;
    reset_n = 1'b0;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    m_ready = 1'b0;
    overrun_clr = 1'b0;

    vecs[0] = '{1'b1, 8'hA5, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'hC3, 2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h01, 2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'hFF, 1, 1'b1, 1'b0};

    #12;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_clr", {31'd0, rx_ready_clr}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single byte: latency and exactly one acknowledge pulse
    rx_ready = 1'b1;
    rx_data = 8'hA5;
    tick();
    chk("single_valid", {31'd0, m_valid}, 32'd1);
    chk("single_data", {24'd0, m_data}, 32'hA5);
    chk("single_count", {27'd0, count}, 32'd1);
    chk("single_clr1", {31'd0, rx_ready_clr}, 32'd1);
    tick();
    rx_ready = 1'b0;
    chk("single_clr2", {31'd0, rx_ready_clr}, 32'd0);
    chk("single_count2", {27'd0, count}, 32'd1);
    sb.push_back(8'hA5);

    // Table of push/pop steps
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_pop) begin
        pop_one();
      end else begin
        send_byte(vecs[i].data, 1'b0, p);
        chk("vec_pulses", p, 32'd1);
      end
      chk("vec_count", {27'd0, count}, vecs[i].exp_count);
      chk("vec_valid", {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      chk("vec_full", {31'd0, full}, {31'd0, vecs[i].exp_full});
    end
    pop_one();
    chk("tbl_empty", {27'd0, count}, 32'd0);

    // Fill to full
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, p);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {27'd0, count}, 32'd16);

    // Overrun while full
    send_byte(8'h55, 1'b1, p);
    chk("ovr_pulses", p, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_count", {27'd0, count}, 32'd16);
    tick();
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Full with simultaneous pop and push of 0x77
    chk("pp_head", {24'd0, m_data}, {24'd0, sb[0]});
    void'(sb.pop_front());
    m_ready = 1'b1;
    rx_ready = 1'b1;
    rx_data = 8'h77;
    tick();
    m_ready = 1'b0;
    chk("pp_count", {27'd0, count}, 32'd16);
    chk("pp_overrun", {31'd0, overrun}, 32'd0);
    chk("pp_clr", {31'd0, rx_ready_clr}, 32'd1);
    tick();
    rx_ready = 1'b0;
    chk("pp_count2", {27'd0, count}, 32'd16);
    sb.push_back(8'h77);
    for (int i = 0; i < 16; i++) pop_one();
    chk("drain_count", {27'd0, count}, 32'd0);
    chk("drain_valid", {31'd0, m_valid}, 32'd0);

    // Second pass across the pointer wrap
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, p);
    chk("pass2_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_one();
    chk("pass2_empty", {31'd0, m_valid}, 32'd0);

    // Level held high for three edges without the receiver dropping it
    rx_ready = 1'b1;
    rx_data = 8'h99;
    tick();
    chk("held_c1", {27'd0, count}, 32'd1);
    tick();
    chk("held_c2", {27'd0, count}, 32'd1);
    tick();
    chk("held_c3", {27'd0, count}, 32'd2);
    rx_ready = 1'b0;
    tick();
    chk("held_c4", {27'd0, count}, 32'd2);
    sb.push_back(8'h99);
    sb.push_back(8'h99);
    pop_one();
    pop_one();

    // Asynchronous reset with count=5 and an acknowledge in flight
    for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), 1'b0, p);
    rx_ready = 1'b1;
    rx_data = 8'hE4;
    tick();
    chk("pre_rst_count", {27'd0, count}, 32'd5);
    chk("pre_rst_clr", {31'd0, rx_ready_clr}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", {27'd0, count}, 32'd0);
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_clr", {31'd0, rx_ready_clr}, 32'd0);
    sb.delete();
    #4;
    reset_n = 1'b1;
    tick();
    chk("post_rst_count", {27'd0, count}, 32'd1);
    chk("post_rst_clr", {31'd0, rx_ready_clr}, 32'd1);
    tick();
    rx_ready = 1'b0;
    sb.push_back(8'hE4);
    pop_one();
    chk("final_count", {27'd0, count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
